// File: rtl/dtcm_port_arbiter.sv
// Single-port DTCM SRAM arbiter merging the core load/store port and the AXI DTCM stream.
// Optional: define DTCM_ARB_STARVE_GUARD_EN to force AXI through after STARVE_LIMIT lost cycles.
module dtcm_port_arbiter #(
  parameter int unsigned RAM_AW       = 12,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              core_dtcm_req,
  input  logic [31:0]       core_dtcm_addr,
  input  logic              core_dtcm_rd0_wr1,
  input  logic [3:0]        core_dtcm_byte_strobe,
  input  logic [31:0]       core_dtcm_write_data,
  output logic              core_dtcm_ready,
  output logic [31:0]       core_dtcm_read_data,
  output logic              core_dtcm_read_data_valid,
  input  logic              AXI_dtcm_access,
  input  logic [31:0]       AXI_tcm_addr,
  input  logic              AXI_tcm_rd0_wr1,
  input  logic [3:0]        AXI_tcm_byte_strobe,
  input  logic [31:0]       AXI_tcm_write_data,
  output logic [31:0]       AXI_dtcm_read_data,
  output logic              AXI_dtcm_read_data_valid,
  output logic              ram_cs,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {A_IDLE, A_PEND, A_ISSUE, A_DONE} a_state_t;

  a_state_t          state_q, state_d;
  logic [RAM_AW-1:0] hold_addr_q;
  logic              hold_wr_q;
  logic [3:0]        hold_strb_q;
  logic [31:0]       hold_wdata_q;
  logic [31:0]       axi_rdata_q;
  logic              core_rv_q;
  logic              axi_grant;
  logic              core_grant;

`ifdef DTCM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  assign axi_grant = !ARESET && (state_q == A_PEND) &&
                     (!core_dtcm_req || (starve_q == 4'(STARVE_LIMIT)));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)
      starve_q <= '0;
    else if ((state_q != A_PEND) || axi_grant)
      starve_q <= '0;
    else if (starve_q != 4'(STARVE_LIMIT))
      starve_q <= starve_q + 4'd1;
  end
`else
  logic [3:0] unused_starve_limit;
  assign unused_starve_limit = 4'(STARVE_LIMIT);
  assign axi_grant = !ARESET && (state_q == A_PEND) && !core_dtcm_req;
`endif

  // Grants are gated by reset so the SRAM and core handshake go quiet immediately.
  assign core_grant      = !ARESET && core_dtcm_req && !axi_grant;
  assign core_dtcm_ready = core_grant;

  always_comb begin
    state_d = state_q;
    case (state_q)
      A_IDLE:  if (AXI_dtcm_access) state_d = A_PEND;
      A_PEND:  if (axi_grant)       state_d = A_ISSUE;
      A_ISSUE:                      state_d = A_DONE;
      A_DONE:                       state_d = A_IDLE;
      default:                      state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= A_IDLE;
      hold_addr_q  <= '0;
      hold_wr_q    <= 1'b0;
      hold_strb_q  <= '0;
      hold_wdata_q <= '0;
      axi_rdata_q  <= '0;
      core_rv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_rv_q <= core_grant && !core_dtcm_rd0_wr1;
      if ((state_q == A_IDLE) && AXI_dtcm_access) begin
        hold_addr_q  <= AXI_tcm_addr[RAM_AW+1:2];
        hold_wr_q    <= AXI_tcm_rd0_wr1;
        hold_strb_q  <= AXI_tcm_byte_strobe;
        hold_wdata_q <= AXI_tcm_write_data;
      end
      if ((state_q == A_ISSUE) && !hold_wr_q)
        axi_rdata_q <= ram_rdata;
    end
  end

  // SRAM data arrives during A_ISSUE; bypass it so data lines up with the valid pulse.
  assign AXI_dtcm_read_data       = ((state_q == A_ISSUE) && !hold_wr_q) ? ram_rdata : axi_rdata_q;
  assign AXI_dtcm_read_data_valid = (state_q == A_ISSUE);
  assign core_dtcm_read_data       = ram_rdata;
  assign core_dtcm_read_data_valid = core_rv_q;

  always_comb begin
    ram_cs    = axi_grant || core_grant;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (axi_grant) begin
      ram_addr  = hold_addr_q;
      ram_we    = hold_wr_q ? hold_strb_q : 4'h0;
      ram_wdata = hold_wdata_q;
    end else if (core_grant) begin
      ram_addr  = core_dtcm_addr[RAM_AW+1:2];
      ram_we    = core_dtcm_rd0_wr1 ? core_dtcm_byte_strobe : 4'h0;
      ram_wdata = core_dtcm_write_data;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_dtcm_addr[31:RAM_AW+2], core_dtcm_addr[1:0],
                              AXI_tcm_addr[31:RAM_AW+2], AXI_tcm_addr[1:0]};

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Directed bench for dtcm_port_arbiter: cycle table plus starvation and reset sequences.
module tb_dtcm_port_arbiter;
  localparam int unsigned RAM_AW       = 12;
  localparam int unsigned STARVE_LIMIT = 4;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              core_dtcm_req;
  logic [31:0]       core_dtcm_addr;
  logic              core_dtcm_rd0_wr1;
  logic [3:0]        core_dtcm_byte_strobe;
  logic [31:0]       core_dtcm_write_data;
  logic              core_dtcm_ready;
  logic [31:0]       core_dtcm_read_data;
  logic              core_dtcm_read_data_valid;
  logic              AXI_dtcm_access;
  logic [31:0]       AXI_tcm_addr;
  logic              AXI_tcm_rd0_wr1;
  logic [3:0]        AXI_tcm_byte_strobe;
  logic [31:0]       AXI_tcm_write_data;
  logic [31:0]       AXI_dtcm_read_data;
  logic              AXI_dtcm_read_data_valid;
  logic              ram_cs;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;

  always #5 ACLK = ~ACLK;

  dtcm_port_arbiter #(.RAM_AW(RAM_AW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .core_dtcm_req(core_dtcm_req), .core_dtcm_addr(core_dtcm_addr),
    .core_dtcm_rd0_wr1(core_dtcm_rd0_wr1), .core_dtcm_byte_strobe(core_dtcm_byte_strobe),
    .core_dtcm_write_data(core_dtcm_write_data), .core_dtcm_ready(core_dtcm_ready),
    .core_dtcm_read_data(core_dtcm_read_data), .core_dtcm_read_data_valid(core_dtcm_read_data_valid),
    .AXI_dtcm_access(AXI_dtcm_access), .AXI_tcm_addr(AXI_tcm_addr),
    .AXI_tcm_rd0_wr1(AXI_tcm_rd0_wr1), .AXI_tcm_byte_strobe(AXI_tcm_byte_strobe),
    .AXI_tcm_write_data(AXI_tcm_write_data), .AXI_dtcm_read_data(AXI_dtcm_read_data),
    .AXI_dtcm_read_data_valid(AXI_dtcm_read_data_valid),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural synchronous SRAM, read data the cycle after chip select.
  logic [31:0] mem [0:(1<<RAM_AW)-1];
  always @(posedge ACLK) begin
    if (ram_cs) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_core(input logic req, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wd);
    core_dtcm_req = req; core_dtcm_rd0_wr1 = wr; core_dtcm_byte_strobe = strb;
    core_dtcm_addr = addr; core_dtcm_write_data = wd;
  endtask

  task automatic set_axi(input logic acc, input logic wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wd);
    AXI_dtcm_access = acc; AXI_tcm_rd0_wr1 = wr; AXI_tcm_byte_strobe = strb;
    AXI_tcm_addr = addr; AXI_tcm_write_data = wd;
  endtask

  typedef struct {
    logic        creq; logic cwr; logic [3:0] cstrb; logic [31:0] caddr; logic [31:0] cwd;
    logic        acc;  logic awr; logic [3:0] astrb; logic [31:0] aaddr; logic [31:0] awd;
    logic        e_rdy; logic e_cs; logic [3:0] e_we; logic [11:0] e_addr; logic [31:0] e_wd;
    logic        e_crv; logic [31:0] e_crd; logic e_av; logic [31:0] e_ard;
  } vec_t;

  localparam int NV = 30;
  vec_t vt [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fields: core{req,wr,strb,addr,wdata} axi{acc,wr,strb,addr,wdata}
    //         expect{ready,cs,we,addr,wdata,core_rv,core_rd,axi_valid,axi_rd}
    vt[0]  = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,0};
    vt[1]  = '{1,1,4'hF,32'h10,32'hDEADBEEF,   0,0,0,0,0,                   1,1,4'hF,12'h4,32'hDEADBEEF, 0,0,0,0};
    vt[2]  = '{1,0,0,32'h10,0,                 0,0,0,0,0,                   1,1,0,12'h4,0,               0,0,0,0};
    vt[3]  = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   1,32'hDEADBEEF,0,0};
    vt[4]  = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,0,0,0,0,                   0,0,0,0};
    vt[5]  = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,1,0,12'h4,0,               0,0,0,0};
    vt[6]  = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,0,0,0,0,                   0,0,1,32'hDEADBEEF};
    vt[7]  = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[8]  = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[9]  = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[10] = '{1,1,4'hF,32'h14,32'hFFFFFFFF,   0,0,0,0,0,                   1,1,4'hF,12'h5,32'hFFFFFFFF, 0,0,0,32'hDEADBEEF};
    vt[11] = '{0,0,0,0,0,                      1,1,4'h3,32'h14,32'h1234,    0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[12] = '{0,0,0,0,0,                      1,1,4'h3,32'h14,32'h1234,    0,1,4'h3,12'h5,32'h1234,     0,0,0,32'hDEADBEEF};
    vt[13] = '{0,0,0,0,0,                      1,1,4'h3,32'h14,32'h1234,    0,0,0,0,0,                   0,0,1,32'hDEADBEEF};
    vt[14] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[15] = '{0,0,0,0,0,                      1,0,0,32'h14,0,              0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[16] = '{0,0,0,0,0,                      1,0,0,32'h14,0,              0,1,0,12'h5,0,               0,0,0,32'hDEADBEEF};
    vt[17] = '{0,0,0,0,0,                      1,0,0,32'h14,0,              0,0,0,0,0,                   0,0,1,32'hFFFF1234};
    vt[18] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hFFFF1234};
    vt[19] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hFFFF1234};
    vt[20] = '{1,0,0,32'h10,0,                 1,0,0,32'h14,0,              1,1,0,12'h4,0,               0,0,0,32'hFFFF1234};
    vt[21] = '{0,0,0,0,0,                      1,0,0,32'h14,0,              0,1,0,12'h5,0,               1,32'hDEADBEEF,0,32'hFFFF1234};
    vt[22] = '{0,0,0,0,0,                      1,0,0,32'h14,0,              0,0,0,0,0,                   0,0,1,32'hFFFF1234};
    vt[23] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hFFFF1234};
    vt[24] = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,0,0,0,0,                   0,0,0,32'hFFFF1234};
    vt[25] = '{1,0,0,32'h14,0,                 1,0,0,32'h10,0,              1,1,0,12'h5,0,               0,0,0,32'hFFFF1234};
    vt[26] = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,1,0,12'h4,0,               1,32'hFFFF1234,0,32'hFFFF1234};
    vt[27] = '{0,0,0,0,0,                      1,0,0,32'h10,0,              0,0,0,0,0,                   0,0,1,32'hDEADBEEF};
    vt[28] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hDEADBEEF};
    vt[29] = '{0,0,0,0,0,                      0,0,0,0,0,                   0,0,0,0,0,                   0,0,0,32'hDEADBEEF};

    // Reset state, with a core request held to show the handshake is gated.
    ARESET = 1'b1;
    set_core(1, 0, 0, 32'h10, 0);
    set_axi(0, 0, 0, 0, 0);
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_ready", 32'(core_dtcm_ready), 0);
    chk("rst_cs", 32'(ram_cs), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_core_rv", 32'(core_dtcm_read_data_valid), 0);
    chk("rst_axi_valid", 32'(AXI_dtcm_read_data_valid), 0);
    chk("rst_axi_rdata", AXI_dtcm_read_data, 0);
    set_core(0, 0, 0, 0, 0);
    ARESET = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      set_core(vt[i].creq, vt[i].cwr, vt[i].cstrb, vt[i].caddr, vt[i].cwd);
      set_axi(vt[i].acc, vt[i].awr, vt[i].astrb, vt[i].aaddr, vt[i].awd);
      #4;
      chk($sformatf("v%0d_ready", i), 32'(core_dtcm_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d_cs", i), 32'(ram_cs), 32'(vt[i].e_cs));
      chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vt[i].e_we));
      if (vt[i].e_cs) chk($sformatf("v%0d_addr", i), 32'(ram_addr), 32'(vt[i].e_addr));
      if (vt[i].e_we != 4'h0) chk($sformatf("v%0d_wdata", i), ram_wdata, vt[i].e_wd);
      chk($sformatf("v%0d_core_rv", i), 32'(core_dtcm_read_data_valid), 32'(vt[i].e_crv));
      if (vt[i].e_crv) chk($sformatf("v%0d_core_rd", i), core_dtcm_read_data, vt[i].e_crd);
      chk($sformatf("v%0d_axi_valid", i), 32'(AXI_dtcm_read_data_valid), 32'(vt[i].e_av));
      chk($sformatf("v%0d_axi_rd", i), AXI_dtcm_read_data, vt[i].e_ard);
      step();
    end

    // Core reads every cycle while an AXI read of 0x14 waits.
    set_core(1, 0, 0, 32'h10, 0);
    set_axi(1, 0, 0, 32'h14, 0);
    #4;
    chk("stv_capture_ready", 32'(core_dtcm_ready), 1);
    step();
`ifdef DTCM_ARB_STARVE_GUARD_EN
    for (int p = 1; p <= int'(STARVE_LIMIT); p++) begin
      #4;
      chk($sformatf("stv_p%0d_ready", p), 32'(core_dtcm_ready), 1);
      chk($sformatf("stv_p%0d_addr", p), 32'(ram_addr), 32'h4);
      step();
    end
    #4;
    chk("stv_force_ready", 32'(core_dtcm_ready), 0);
    chk("stv_force_cs", 32'(ram_cs), 1);
    chk("stv_force_addr", 32'(ram_addr), 32'h5);
    step();
`else
    for (int p = 1; p <= 20; p++) begin
      #4;
      chk($sformatf("stv_p%0d_ready", p), 32'(core_dtcm_ready), 1);
      chk($sformatf("stv_p%0d_axi_valid", p), 32'(AXI_dtcm_read_data_valid), 0);
      step();
    end
    core_dtcm_req = 1'b0;
    #4;
    chk("stv_release_cs", 32'(ram_cs), 1);
    chk("stv_release_addr", 32'(ram_addr), 32'h5);
    step();
`endif
    #4;
    chk("stv_issue_valid", 32'(AXI_dtcm_read_data_valid), 1);
    chk("stv_issue_data", AXI_dtcm_read_data, 32'hFFFF1234);
    step();
    set_core(0, 0, 0, 0, 0);
    set_axi(0, 0, 0, 0, 0);
    #4;
    chk("stv_done_valid", 32'(AXI_dtcm_read_data_valid), 0);
    step();
    step();

    // Reset while AXI is pending and a core read was just granted.
    set_core(1, 0, 0, 32'h10, 0);
    set_axi(1, 0, 0, 32'h10, 0);
    step();
    #4;
    chk("rpend_ready_before", 32'(core_dtcm_ready), 1);
    ARESET = 1'b1;
    #1;
    chk("rpend_ready", 32'(core_dtcm_ready), 0);
    chk("rpend_cs", 32'(ram_cs), 0);
    chk("rpend_core_rv", 32'(core_dtcm_read_data_valid), 0);
    chk("rpend_axi_rd", AXI_dtcm_read_data, 0);
    set_core(0, 0, 0, 0, 0);
    set_axi(0, 0, 0, 0, 0);
    step();
    ARESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("rpend_after%0d_core_rv", c), 32'(core_dtcm_read_data_valid), 0);
      chk($sformatf("rpend_after%0d_axi_valid", c), 32'(AXI_dtcm_read_data_valid), 0);
      chk($sformatf("rpend_after%0d_cs", c), 32'(ram_cs), 0);
      step();
    end

    // Reset in A_ISSUE, then confirm the FSM restarts from A_IDLE.
    set_axi(1, 0, 0, 32'h14, 0);
    step();
    step();
    ARESET = 1'b1;
    #1;
    chk("riss_axi_valid", 32'(AXI_dtcm_read_data_valid), 0);
    chk("riss_axi_rd", AXI_dtcm_read_data, 0);
    set_axi(0, 0, 0, 0, 0);
    step();
    ARESET = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk($sformatf("riss_after%0d_axi_valid", c), 32'(AXI_dtcm_read_data_valid), 0);
      chk($sformatf("riss_after%0d_cs", c), 32'(ram_cs), 0);
      step();
    end
    set_axi(1, 0, 0, 32'h14, 0);
    #4;
    chk("riss_new_capture_cs", 32'(ram_cs), 0);
    step();
    #4;
    chk("riss_new_issue_cs", 32'(ram_cs), 1);
    chk("riss_new_issue_addr", 32'(ram_addr), 32'h5);
    step();
    #4;
    chk("riss_new_valid", 32'(AXI_dtcm_read_data_valid), 1);
    chk("riss_new_data", AXI_dtcm_read_data, 32'hFFFF1234);
    step();
    set_axi(0, 0, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
